// File: rtl/alu_li_sequencer_if.sv
// Shared ALU op encoding and the load-constant request channel
// (valid/ready handshake) for the ALU_LI sequencer.
package alu_li_pkg;
  typedef enum logic [3:0] {
    ALU_CL  = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_LI  = 4'h6
  } alu_op_e;
endpackage

interface alu_li_req_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_imm;
  logic [DATA_W-1:0] req_base;
  logic [3:0]        req_mask;

  modport master (
    output req_valid,
    output req_imm,
    output req_base,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_imm,
    input  req_base,
    input  req_mask,
    output req_ready
  );
endinterface

// File: rtl/alu_li_sequencer.sv
// Builds a 16-bit constant one nibble per cycle through the shared
// execute ALU using ALU_LI, then reports it with a done pulse.
module alu_li_sequencer
  import alu_li_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  alu_li_req_if.slave       req,
  output alu_op_e           alu_op,
  output logic [DATA_W-1:0] alu_op0,
  output logic [DATA_W-1:0] alu_op1,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] dval_q, dval_d;

  logic [3:0]        mask_rest;
  logic [3:0]        nib;

  function automatic logic [1:0] low_bit(
    input logic [3:0] m
  );
    logic [1:0] r;
    r = 2'd3;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    return r;
  endfunction

  // Nibbles are issued in ascending order, so every bit left
  // after clearing idx lies above it.
  assign mask_rest = mask_q & ~(4'b0001 << idx_q);
  assign nib       = imm_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    imm_d         = imm_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    dval_d        = dval_q;
    alu_op        = ALU_CL;
    alu_op0       = '0;
    alu_op1       = '0;
    req.req_ready = 1'b0;
    done_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req.req_ready = ~flush;
        if (req.req_valid && !flush) begin
          acc_d  = req.req_base;
          imm_d  = req.req_imm;
          mask_d = req.req_mask;
          if (req.req_mask != 4'b0) begin
            idx_d   = low_bit(req.req_mask);
            state_d = STEP;
          end else begin
            state_d = DONE;
          end
        end
      end
      STEP: begin
        alu_op  = ALU_LI;
        alu_op0 = acc_q;
        alu_op1 = {{(DATA_W-6){1'b0}}, idx_q, nib};
        acc_d   = alu_result;
        mask_d  = mask_rest;
        idx_d   = low_bit(mask_rest);
        if (mask_rest == 4'b0) state_d = DONE;
        if (flush)             state_d = IDLE;
      end
      DONE: begin
        done_valid = ~flush;
        if (!flush) dval_d = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      imm_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      dval_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      imm_q   <= imm_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      dval_q  <= dval_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done_value = (state_q == DONE) ? acc_q : dval_q;

endmodule
